// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: start/operand request and HI/LO result bundle between the control unit and the multiply/divide unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic start;
    logic [1:0] op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic busy;
    logic done;
    logic div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output start, op, a_in, b_in, input busy, done, div_zero, hi, lo);
    modport slave (input start, op, a_in, b_in, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed/unsigned multiply and divide, one result bit per cycle, holding HI/LO.
module mult_div_unit #(parameter int WIDTH = 32) (
    input logic clock,
    input logic reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIN} fsmState;
    fsmState state, nextState;
    logic divOp, negRes, negRem, zeroDiv;
    logic [CW-1:0] count;
    logic [WIDTH-1:0] magA, magB, inMagA, inMagB, remNext, quotient, remainder;
    logic [2*WIDTH-1:0] acc, product;
    logic [WIDTH:0] mulSum, shifted, diff;
    logic aNeg, bNeg, divByZero, geq;
    assign aNeg = ~bus.op[0] & bus.a_in[WIDTH-1];
    assign bNeg = ~bus.op[0] & bus.b_in[WIDTH-1];
    assign inMagA = aNeg ? -bus.a_in : bus.a_in;
    assign inMagB = bNeg ? -bus.b_in : bus.b_in;
    assign divByZero = bus.op[1] && bus.b_in == '0;
    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each cycle.
    assign mulSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? magA : WIDTH'(0)};
    // Divide: acc = {partial remainder, dividend bits / quotient bits}, shifted left each cycle.
    assign shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign geq = shifted >= {1'b0, magB};
    assign diff = shifted - {1'b0, magB};
    assign remNext = geq ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign product = negRes ? -acc : acc;
    assign quotient = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign remainder = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else state <= nextState;
    end
    always_comb begin
        nextState = state == IDLE ? (bus.start ? (divByZero ? FIN : RUN) : IDLE)
                  : state == RUN ? (count == '0 ? FIN : RUN)
                  : IDLE;
    end
    always_comb begin
        bus.busy = state != IDLE;
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            divOp <= 1'b0;
            negRes <= 1'b0;
            negRem <= 1'b0;
            zeroDiv <= 1'b0;
            count <= '0;
            magA <= '0;
            magB <= '0;
            acc <= '0;
            bus.done <= 1'b0;
            bus.div_zero <= 1'b0;
            bus.hi <= '0;
            bus.lo <= '0;
        end else begin
            bus.done <= 1'b0;
            bus.div_zero <= 1'b0;
            if (state == IDLE && bus.start) begin
                divOp <= bus.op[1];
                negRes <= aNeg ^ bNeg;
                negRem <= aNeg;
                zeroDiv <= divByZero;
                count <= CW'(WIDTH - 1);
                magA <= inMagA;
                magB <= inMagB;
                acc <= {{WIDTH{1'b0}}, bus.op[1] ? inMagA : inMagB};
            end else if (state == RUN) begin
                count <= count - 1'b1;
                acc <= divOp ? {remNext, acc[WIDTH-2:0], geq} : {mulSum, acc[WIDTH-1:1]};
            end else if (state == FIN) begin
                bus.done <= 1'b1;
                bus.div_zero <= zeroDiv;
                if (!zeroDiv) begin
                    bus.hi <= divOp ? remainder : product[2*WIDTH-1:WIDTH];
                    bus.lo <= divOp ? quotient : product[WIDTH-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed checks of mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;
    logic [31:0] expHi = '0;
    logic [31:0] expLo = '0;
    mult_div_unit_if #(.WIDTH(32)) bus();
    mult_div_unit #(.WIDTH(32)) dut(.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hi, input logic [31:0] lo);
        longint sa, sb, sq, sr;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (op == 2'd0) return sa * sb;
        if (op == 2'd1) return ua * ub;
        if (b == 32'b0) return {hi, lo};
        if (op == 2'd2) begin
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle with start already dropped.
    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int cyc = 0;
        int busyCyc = 0;
        int lat;
        logic [63:0] r;
        lat = (op[1] && b == 32'b0) ? 1 : 33;
        r = model(op, a, b, expHi, expLo);
        bus.start = 1'b1;
        bus.op = op;
        bus.a_in = a;
        bus.b_in = b;
        @(negedge clock);
        while (!bus.done && cyc < 100) begin
            if (bus.busy) busyCyc++;
            bus.start = 1'($urandom_range(0, 1));
            bus.op = 2'($urandom_range(0, 3));
            bus.a_in = $urandom;
            bus.b_in = $urandom;
            @(negedge clock);
            cyc++;
        end
        bus.start = 1'b0;
        check("latency", 64'(cyc), 64'(lat));
        check("busy_cycles", 64'(busyCyc), 64'(lat));
        check("busy_in_done", 64'(bus.busy), 64'(0));
        check("div_zero", 64'(bus.div_zero), 64'(op[1] && b == 32'b0));
        check("hi", 64'(bus.hi), 64'(r[63:32]));
        check("lo", 64'(bus.lo), 64'(r[31:0]));
        expHi = r[63:32];
        expLo = r[31:0];
    endtask

    task automatic idleCycle();
        @(negedge clock);
        check("done_pulse", 64'(bus.done), 64'(0));
        check("div_zero_pulse", 64'(bus.div_zero), 64'(0));
    endtask

    initial begin
        logic [31:0] a, b;
        bus.start = 1'b0;
        bus.op = 2'd0;
        bus.a_in = '0;
        bus.b_in = '0;
        repeat (3) @(negedge clock);
        check("rst_hi", 64'(bus.hi), 64'(0));
        check("rst_lo", 64'(bus.lo), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_dz", 64'(bus.div_zero), 64'(0));
        reset = 1'b1;
        @(negedge clock);
        runOp(2'd0, 32'hFFFFFFFE, 32'd3);
        check("mult_neg_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
        check("mult_neg_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFA);
        idleCycle();
        runOp(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        idleCycle();
        runOp(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        idleCycle();
        runOp(2'd2, 32'hFFFFFFF9, 32'd2);
        runOp(2'd3, 32'd100, 32'd7);
        check("divu_lo", 64'(bus.lo), 64'd14);
        idleCycle();
        runOp(2'd3, 32'h3412, 32'h100);
        idleCycle();
        runOp(2'd3, 32'd5, 32'd0);
        check("dz_keep_hi", 64'(bus.hi), 64'h12);
        check("dz_keep_lo", 64'(bus.lo), 64'h34);
        idleCycle();
        runOp(2'd1, 32'd1000, 32'd1000);
        idleCycle();
        runOp(2'd2, 32'h80000000, 32'hFFFFFFFF);
        idleCycle();
        bus.start = 1'b1;
        bus.op = 2'd2;
        bus.a_in = 32'd12345;
        bus.b_in = 32'd17;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("mid_rst_busy", 64'(bus.busy), 64'(0));
        check("mid_rst_hi", 64'(bus.hi), 64'(0));
        check("mid_rst_lo", 64'(bus.lo), 64'(0));
        expHi = '0;
        expLo = '0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done || bus.busy) check("mid_rst_quiet", {bus.done, bus.busy}, 64'(0));
        end
        runOp(2'd0, 32'd6, 32'd7);
        check("mult_6x7", 64'(bus.lo), 64'd42);
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : $urandom;
            if ($urandom_range(0, 1) == 1) idleCycle();
            runOp(2'($urandom_range(0, 3)), a, b);
        end
        idleCycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
